// File: rtl/bp_fe_icache_mem_model.sv
// Fixed-latency, single-outstanding backing memory behind the I$ memory port.
// Define BP_FE_ICACHE_MEM_MODEL_BACKPRESSURE_EN for LFSR-driven command backpressure.
module bp_fe_icache_mem_model #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int mem_els_p       = 1024,
  parameter int latency_p       = 4,
  parameter int payload_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       mem_cmd_v_i,
  output logic                       mem_cmd_ready_o,
  input  logic [1:0]                 mem_cmd_opcode_i,
  input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
  input  logic [payload_width_p-1:0] mem_cmd_payload_i,
  input  logic [63:0]                mem_cmd_data_i,
  output logic                       mem_resp_v_o,
  input  logic                       mem_resp_yumi_i,
  output logic [1:0]                 mem_resp_opcode_o,
  output logic [paddr_width_p-1:0]   mem_resp_addr_o,
  output logic [payload_width_p-1:0] mem_resp_payload_o,
  output logic [block_width_p-1:0]   mem_resp_data_o
);

  localparam int dwords_lp      = block_width_p / 64;
  localparam int offset_bits_lp = $clog2(block_width_p / 8);
  localparam int idx_bits_lp    = $clog2(mem_els_p);
  localparam int dw_bits_lp     = (dwords_lp > 1) ? $clog2(dwords_lp) : 1;
  localparam int cnt_bits_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;

  localparam logic [1:0] op_uc_rd_lp = 2'd1;
  localparam logic [1:0] op_uc_wr_lp = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e                     state_r, state_n;
  logic [cnt_bits_lp-1:0]     cnt_r;
  logic [block_width_p-1:0]   mem_r [mem_els_p];
  logic [mem_els_p-1:0]       written_r;
  logic                       accept;
  logic                       bp_ok;
  logic [idx_bits_lp-1:0]     blk_idx;
  logic [dw_bits_lp-1:0]      dw_idx;
  logic [block_width_p-1:0]   cur_block;
  logic [block_width_p-1:0]   merged_block;
  logic [block_width_p-1:0]   resp_data_n;
  logic [63:0]                rd_dword;

  // Unwritten blocks read back {block index, dword index} in every dword.
  function automatic logic [block_width_p-1:0] pattern(input logic [idx_bits_lp-1:0] b);
    logic [block_width_p-1:0] blk;
    for (int i = 0; i < dwords_lp; i++) begin
      blk[i*64 +: 64] = {32'(b), 32'(i)};
    end
    return blk;
  endfunction

  assign blk_idx   = mem_cmd_addr_i[offset_bits_lp +: idx_bits_lp];
  assign dw_idx    = (dwords_lp > 1) ? mem_cmd_addr_i[3 +: dw_bits_lp] : '0;
  assign cur_block = written_r[blk_idx] ? mem_r[blk_idx] : pattern(blk_idx);
  assign accept    = mem_cmd_v_i & mem_cmd_ready_o;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    merged_block = cur_block;
    rd_dword     = '0;
    for (int i = 0; i < dwords_lp; i++) begin
      if (dw_bits_lp'(i) == dw_idx) begin
        rd_dword                = cur_block[i*64 +: 64];
        merged_block[i*64 +: 64] = mem_cmd_data_i;
      end
    end
  end

  always_comb begin
    case (mem_cmd_opcode_i)
      op_uc_rd_lp: resp_data_n = block_width_p'(rd_dword);
      op_uc_wr_lp: resp_data_n = '0;
      default:     resp_data_n = cur_block;
    endcase
  end

  // NOTE: the storage array is not reset; clearing written_r makes every block read as the pattern again.
  always_ff @(posedge clk_i) begin
    if (accept && mem_cmd_opcode_i == op_uc_wr_lp) begin
      mem_r[blk_idx] <= merged_block;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      written_r <= '0;
    end else if (accept && mem_cmd_opcode_i == op_uc_wr_lp) begin
      written_r[blk_idx] <= 1'b1;
    end
  end

`ifdef BP_FE_ICACHE_MEM_MODEL_BACKPRESSURE_EN
  logic [7:0] lfsr_r;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_r <= 8'h5A;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign bp_ok = ~lfsr_r[0];
`else
  assign bp_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // The counter is loaded with latency_p-1 and RESP is entered as it steps to zero,
  // so valid rises exactly latency_p cycles after accept.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: if (accept) state_n = (latency_p == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_r <= cnt_bits_lp'(1)) state_n = ST_RESP;
      ST_RESP: if (mem_resp_yumi_i) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_cmd_ready_o = (state_r == ST_IDLE) & reset_n_i & bp_ok;
    mem_resp_v_o    = (state_r == ST_RESP);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r              <= '0;
      mem_resp_opcode_o  <= '0;
      mem_resp_addr_o    <= '0;
      mem_resp_payload_o <= '0;
      mem_resp_data_o    <= '0;
    end else if (accept) begin
      cnt_r              <= cnt_bits_lp'(latency_p - 1);
      mem_resp_opcode_o  <= mem_cmd_opcode_i;
      mem_resp_addr_o    <= mem_cmd_addr_i;
      mem_resp_payload_o <= mem_cmd_payload_i;
      mem_resp_data_o    <= resp_data_n;
    end else if (state_r == ST_WAIT && cnt_r != '0) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_fe_icache_mem_model.sv
// Self-checking bench for bp_fe_icache_mem_model: directed plan plus randomized traffic
// compared against an array-based memory model.
module tb_bp_fe_icache_mem_model;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_v = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_opcode = '0;
  logic [39:0]  cmd_addr = '0;
  logic [15:0]  cmd_payload = '0;
  logic [63:0]  cmd_data = '0;
  logic         resp_v;
  logic         resp_yumi = 1'b0;
  logic [1:0]   resp_opcode;
  logic [39:0]  resp_addr;
  logic [15:0]  resp_payload;
  logic [511:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] m_mem [1024];
  bit           m_wr  [1024];

  always #5 clk = ~clk;

  bp_fe_icache_mem_model #(
    .paddr_width_p(40), .block_width_p(512), .mem_els_p(1024),
    .latency_p(LAT), .payload_width_p(16)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(cmd_ready),
    .mem_cmd_opcode_i(cmd_opcode), .mem_cmd_addr_i(cmd_addr),
    .mem_cmd_payload_i(cmd_payload), .mem_cmd_data_i(cmd_data),
    .mem_resp_v_o(resp_v), .mem_resp_yumi_i(resp_yumi),
    .mem_resp_opcode_o(resp_opcode), .mem_resp_addr_o(resp_addr),
    .mem_resp_payload_o(resp_payload), .mem_resp_data_o(resp_data)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] model_block(input int b);
    logic [511:0] blk;
    if (m_wr[b]) return m_mem[b];
    for (int i = 0; i < 8; i++) blk[i*64 +: 64] = {32'(b), 32'(i)};
    return blk;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 1024; i++) m_wr[i] = 1'b0;
  endfunction

  // Returns the expected response data and commits writes to the model.
  function automatic logic [511:0] model_access(input logic [1:0] op, input logic [39:0] addr,
                                                input logic [63:0] wd);
    int b = int'((addr / 64) % 1024);
    int d = int'((addr / 8) % 8);
    logic [511:0] blk = model_block(b);
    case (op)
      2'd1: return {448'd0, blk[d*64 +: 64]};
      2'd2: begin
        blk[d*64 +: 64] = wd;
        m_mem[b] = blk;
        m_wr[b]  = 1'b1;
        return '0;
      end
      default: return blk;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [39:0] addr,
                       input logic [15:0] pl, input logic [63:0] wd);
    int n = 0;
    @(negedge clk);
    cmd_v = 1'b1; cmd_opcode = op; cmd_addr = addr; cmd_payload = pl; cmd_data = wd;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_v = 1'b0;
    cmd_data = $urandom;
  endtask

  task automatic expect_resp(input logic [1:0] op, input logic [39:0] addr, input logic [15:0] pl,
                             input logic [511:0] exp, input int hold, output logic [511:0] got);
    int  cycles = 1;
    bit  saw_ready = 0;
    while (!resp_v && cycles < 64) begin
      if (cmd_ready) saw_ready = 1;
      @(negedge clk);
      cycles++;
    end
    check("resp_latency", cycles, LAT);
    check("ready_low_in_wait", saw_ready, 1'b0);
    check("resp_opcode", resp_opcode, op);
    check("resp_addr", resp_addr, addr);
    check("resp_payload", resp_payload, pl);
    check("resp_data", resp_data, exp);
    got = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid_ready", {resp_v, cmd_ready}, 2'b10);
      check("hold_data", resp_data, exp);
      check("hold_fields", {resp_opcode, resp_addr, resp_payload}, {op, addr, pl});
    end
    resp_yumi = 1'b1;
    check("yumi_only_in_resp", resp_v, 1'b1);
    @(negedge clk);
    resp_yumi = 1'b0;
    check("valid_drops_after_yumi", resp_v, 1'b0);
`ifndef BP_FE_ICACHE_MEM_MODEL_BACKPRESSURE_EN
    check("ready_after_yumi", cmd_ready, 1'b1);
`endif
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [39:0] addr, input logic [15:0] pl,
                         input logic [63:0] wd, input int hold, output logic [511:0] got);
    logic [511:0] exp = model_access(op, addr, wd);
    issue(op, addr, pl, wd);
    expect_resp(op, addr, pl, exp, hold, got);
  endtask

  initial begin
    logic [511:0] got;
    logic [63:0]  dw;
    int           vcount;
    model_clear();

    repeat (3) @(negedge clk);
    check("reset_ready", cmd_ready, 1'b0);
    check("reset_valid", resp_v, 1'b0);
    check("reset_data", resp_data, '0);
    check("reset_fields", {resp_opcode, resp_addr, resp_payload}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    // Block read of block 2 returns the pattern.
    run_cmd(2'd0, 40'h80, 16'hA5C3, 64'h0, 0, got);
    dw = got[63:0];
    check("blk2_dword0", dw, 64'h0000_0002_0000_0000);
    dw = got[511:448];
    check("blk2_dword7", dw, 64'h0000_0002_0000_0007);

    // Uncached write then readback.
    run_cmd(2'd2, 40'h88, 16'h0101, 64'hDEAD_BEEF_0123_4567, 0, got);
    check("write_resp_zero", got, '0);
    run_cmd(2'd0, 40'h80, 16'h0202, 64'h0, 0, got);
    dw = got[127:64];
    check("written_dword1", dw, 64'hDEAD_BEEF_0123_4567);
    dw = got[191:128];
    check("unwritten_dword2", dw, 64'h0000_0002_0000_0002);
    run_cmd(2'd1, 40'h88, 16'h0303, 64'h0, 0, got);
    check("uc_read", got, {448'd0, 64'hDEAD_BEEF_0123_4567});
    run_cmd(2'd1, 40'h1_0088, 16'h0404, 64'h0, 0, got);
    check("alias_read", got, {448'd0, 64'hDEAD_BEEF_0123_4567});

    // Long yumi hold with reserved opcode (block read).
    run_cmd(2'd3, 40'h1C0, 16'hBEEF, 64'h0, 10, got);

    // Reset during WAIT drops the response and reinitialises memory.
    void'(model_access(2'd0, 40'h80, 64'h0));
    issue(2'd0, 40'h80, 16'h7777, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", resp_v, 1'b0);
    check("midreset_ready", cmd_ready, 1'b0);
    check("midreset_data", resp_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_v) vcount++;
    end
    check("no_resp_after_reset", vcount, 0);
    run_cmd(2'd0, 40'h80, 16'h0505, 64'h0, 0, got);
    check("pattern_after_reset", got, model_block(2));

    // Randomized traffic over a few blocks with aliasing upper bits.
    for (int i = 0; i < 60; i++) begin
      logic [39:0] a;
      logic [1:0]  op;
      logic [63:0] wd;
      a  = (40'($urandom_range(0, 3)) << 16) | (40'($urandom_range(0, 7)) << 6)
         | 40'($urandom_range(0, 63));
      op = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      run_cmd(op, a, 16'($urandom), wd, int'($urandom_range(0, 3)), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
